window_fetcher: RTL and testbench

- Streaming 2-D neighbourhood extractor for raster-order pixel streams, with one pixel per valid cycle.
- For each output centre pixel, presents the full WINDOW_HEIGHT x WINDOW_WIDTH neighbourhood, plus the centre column/row.
- Sits between a pixel source (decoder, async FIFO read side) and window-consuming kernels (convolution, floating-point filters).
- Built from line buffers plus a window shift register; no backpressure.

---
 rtl/window_fetcher_pkg.sv | 30 +++
 rtl/window_fetcher_line_buffer.sv | 27 ++
 rtl/window_fetcher.sv | 244 ++++++++++++++++++++++++
 tb/tb_window_fetcher.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_fetcher_pkg.sv
// Shared helpers for window_fetcher: coordinate widths, centre-offset math and
// virtual-pixel generator state encodings.
package window_fetcher_pkg;

  // Width of a coordinate that must index n positions (never below one bit).
  function automatic int unsigned coord_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Centre position inside a window dimension, including the signed shift.
  function automatic int center_offset(input int unsigned size, input int offset);
    return (int'(size) - 1) / 2 + offset;
  endfunction

  // Taps that trail the centre (to the right / below) in a window dimension.
  function automatic int unsigned trail_count(input int unsigned size, input int offset);
    return unsigned'(int'(size) - 1 - center_offset(size, offset));
  endfunction

  // Flat bit offset of tap [row][col] inside a packed window.
  function automatic int unsigned tap_lsb(input int unsigned row, input int unsigned col,
                                          input int unsigned win_w, input int unsigned dw);
    return (row * win_w + col) * dw;
  endfunction

  localparam int unsigned VSTATE_W = 1;
  localparam logic [VSTATE_W-1:0] VS_IDLE = 1'b0;
  localparam logic [VSTATE_W-1:0] VS_RUN  = 1'b1;

endpackage

// File: rtl/window_fetcher_line_buffer.sv
// One image row of pixel storage: single write port, combinational read port,
// so a read-before-write at the same address returns the previous row's pixel.
module line_buffer
  import window_fetcher_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 5
) (
  input  logic                            i_clk,
  input  logic                            i_we,
  input  logic [coord_width(DEPTH)-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0]           i_wdata,
  input  logic [coord_width(DEPTH)-1:0]   i_raddr,
  output logic [DATA_WIDTH-1:0]           o_rdata_c
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin : mem_wr
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/window_fetcher.sv
// Streaming 2-D neighbourhood extractor: line buffers feed a window shift register.
// Optional WINDOW_FETCHER_SEQ_CHECK_EN adds a sticky raster-order error flag (seq_err_o).
module window_fetcher
  import window_fetcher_pkg::*;
#(
  parameter int unsigned DATA_WIDTH                  = 8,
  parameter int unsigned IMAGE_WIDTH                 = 5,
  parameter int unsigned IMAGE_HEIGHT                = 5,
  parameter int unsigned WINDOW_WIDTH                = 3,
  parameter int unsigned WINDOW_HEIGHT               = 3,
  parameter int          WINDOW_WIDTH_CENTER_OFFSET  = 0,
  parameter int          WINDOW_HEIGHT_CENTER_OFFSET = 0,
  parameter int unsigned BORDER_EXTENSION_CONSTANT   = 0,
  parameter int unsigned BORDER_ENABLE               = 0
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic [DATA_WIDTH-1:0]                             data_i,
  input  logic [coord_width(IMAGE_WIDTH)-1:0]               col_i,
  input  logic [coord_width(IMAGE_HEIGHT)-1:0]              row_i,
  input  logic                                              valid_i,
  output logic [WINDOW_HEIGHT*WINDOW_WIDTH*DATA_WIDTH-1:0]  window_o,
  output logic [coord_width(IMAGE_WIDTH)-1:0]               col_o,
  output logic [coord_width(IMAGE_HEIGHT)-1:0]              row_o,
  output logic                                              valid_o
`ifdef WINDOW_FETCHER_SEQ_CHECK_EN
  ,
  output logic                                              seq_err_o
`endif
);

  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned IW     = IMAGE_WIDTH;
  localparam int unsigned IH     = IMAGE_HEIGHT;
  localparam int unsigned WW     = WINDOW_WIDTH;
  localparam int unsigned WH     = WINDOW_HEIGHT;
  localparam int unsigned CW     = coord_width(IW);
  localparam int unsigned RW     = coord_width(IH);
  localparam int unsigned XT     = trail_count(WW, WINDOW_WIDTH_CENTER_OFFSET);
  localparam int unsigned YT     = trail_count(WH, WINDOW_HEIGHT_CENTER_OFFSET);
  localparam int unsigned XW     = coord_width(IW + XT + 1);
  localparam int unsigned YW     = coord_width(IH + YT + 1);
  localparam int unsigned X_LAST = IW - 1 + XT;
  localparam int unsigned Y_LAST = IH - 1 + YT;
  localparam int unsigned NLB    = (WH > 1) ? WH - 1 : 1;
  localparam logic [DW-1:0] PAD  = DW'(BORDER_EXTENSION_CONSTANT);

  typedef logic [DW-1:0]      pixel_t;
  typedef pixel_t [WW-1:0]    win_row_t;
  typedef win_row_t [WH-1:0]  win_t;

  logic [VSTATE_W-1:0] r_state;
  logic [VSTATE_W-1:0] w_state_next;
  logic [XW-1:0]       r_vx;
  logic [XW-1:0]       w_vx_next;
  logic [YW-1:0]       r_vy;
  logic [YW-1:0]       w_vy_next;
  logic                w_virt;
  logic                w_step;
  logic [XW-1:0]       w_x;
  logic [YW-1:0]       w_y;
  pixel_t              w_pix;
  logic                w_in_row;
  logic [CW-1:0]       w_addr;
  pixel_t              w_lb_rd [NLB];
  pixel_t              w_lb_wr [NLB];
  win_t                r_win;
  win_t                w_win_next;
  win_t                w_win_masked;
  logic                w_emit;
  int                  w_tx;
  int                  w_ty;

  // Virtual pixels fill idle cycles past the right edge and below the last row.
  always_comb begin : vp_next
    w_state_next = r_state;
    w_vx_next    = r_vx;
    w_vy_next    = r_vy;
    w_virt       = 1'b0;
    if (valid_i) begin
      w_state_next = VS_IDLE;
      if ((BORDER_ENABLE != 0) && (XW'(col_i) == XW'(IW - 1))) begin
        if (XT > 0) begin
          w_state_next = VS_RUN;
          w_vx_next    = XW'(IW);
          w_vy_next    = YW'(row_i);
        end else if ((YT > 0) && (YW'(row_i) == YW'(IH - 1))) begin
          w_state_next = VS_RUN;
          w_vx_next    = '0;
          w_vy_next    = YW'(IH);
        end
      end
    end else if (r_state == VS_RUN) begin
      w_virt = 1'b1;
      if (r_vx == XW'(X_LAST)) begin
        if ((r_vy >= YW'(IH - 1)) && (r_vy != YW'(Y_LAST))) begin
          w_vx_next = '0;
          w_vy_next = r_vy + YW'(1);
        end else begin
          w_state_next = VS_IDLE;
        end
      end else begin
        w_vx_next = r_vx + XW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : vp_state
    if (rst_i) begin
      r_state <= VS_IDLE;
      r_vx    <= '0;
      r_vy    <= '0;
    end else begin
      r_state <= w_state_next;
      r_vx    <= w_vx_next;
      r_vy    <= w_vy_next;
    end
  end

  assign w_step   = valid_i | w_virt;
  assign w_x      = valid_i ? XW'(col_i) : r_vx;
  assign w_y      = valid_i ? YW'(row_i) : r_vy;
  assign w_pix    = valid_i ? data_i : PAD;
  assign w_in_row = (w_x < XW'(IW));
  assign w_addr   = CW'(w_x);

  // Line buffers form a row cascade: each passes its old pixel to the next one up.
  always_comb begin : lb_chain
    w_lb_wr[0] = w_pix;
    for (int k = 1; k < int'(NLB); k++) begin
      w_lb_wr[k] = w_lb_rd[k-1];
    end
  end

  for (genvar k = 0; k < int'(WH) - 1; k++) begin : g_lb
    line_buffer #(
      .DATA_WIDTH (DW),
      .DEPTH      (IW)
    ) u_line_buffer (
      .i_clk     (clk_i),
      .i_we      (w_step & w_in_row),
      .i_waddr   (w_addr),
      .i_wdata   (w_lb_wr[k]),
      .i_raddr   (w_addr),
      .o_rdata_c (w_lb_rd[k])
    );
  end

  if (WH == 1) begin : g_no_lb
    assign w_lb_rd[0] = '0;
  end

  // Shift one column left; bottom row is the current pixel, upper rows the buffers.
  always_comb begin : win_shift
    w_win_next = r_win;
    for (int i = 0; i < int'(WH); i++) begin
      for (int j = 0; j < int'(WW) - 1; j++) begin
        w_win_next[i][j] = r_win[i][j+1];
      end
    end
    w_win_next[WH-1][WW-1] = w_pix;
    for (int i = 0; i < int'(WH) - 1; i++) begin
      w_win_next[i][WW-1] = w_in_row ? w_lb_rd[int'(WH) - 2 - i] : PAD;
    end
  end

  // Taps outside the image (including stale previous-row/frame data) become PAD.
  always_comb begin : win_mask
    w_win_masked = w_win_next;
    w_tx         = 0;
    w_ty         = 0;
    for (int i = 0; i < int'(WH); i++) begin
      for (int j = 0; j < int'(WW); j++) begin
        w_tx = int'(w_x) + j - (int'(WW) - 1);
        w_ty = int'(w_y) + i - (int'(WH) - 1);
        if ((w_tx < 0) || (w_tx >= int'(IW)) || (w_ty < 0) || (w_ty >= int'(IH))) begin
          w_win_masked[i][j] = PAD;
        end
      end
    end
  end

  assign w_emit = w_step &&
                  ((BORDER_ENABLE != 0) ? ((w_x >= XW'(XT)) && (w_y >= YW'(YT)))
                                        : (valid_i && (w_x >= XW'(WW - 1)) && (w_y >= YW'(WH - 1))));

  always_ff @(posedge clk_i or posedge rst_i) begin : out_reg
    if (rst_i) begin
      r_win    <= '0;
      valid_o  <= 1'b0;
      window_o <= '0;
      col_o    <= '0;
      row_o    <= '0;
    end else begin
      valid_o <= w_emit;
      if (w_step) begin
        r_win <= w_win_next;
      end
      if (w_emit) begin
        window_o <= w_win_masked;
        col_o    <= CW'(w_x - XW'(XT));
        row_o    <= RW'(w_y - YW'(YT));
      end
    end
  end

`ifdef WINDOW_FETCHER_SEQ_CHECK_EN
  logic          r_have_prev;
  logic [CW-1:0] r_prev_col;
  logic [RW-1:0] r_prev_row;
  logic          w_seq_ok;

  // (0,0) is always a legal frame restart; otherwise expect the raster successor.
  always_comb begin : seq_cmp
    w_seq_ok = 1'b1;
    if (valid_i && r_have_prev && !((col_i == '0) && (row_i == '0))) begin
      if (r_prev_col == CW'(IW - 1)) begin
        w_seq_ok = (col_i == '0) && (row_i == r_prev_row + RW'(1));
      end else begin
        w_seq_ok = (col_i == r_prev_col + CW'(1)) && (row_i == r_prev_row);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : seq_reg
    if (rst_i) begin
      r_have_prev <= 1'b0;
      r_prev_col  <= '0;
      r_prev_row  <= '0;
      seq_err_o   <= 1'b0;
    end else begin
      if (!w_seq_ok) begin
        seq_err_o <= 1'b1;
      end
      if (valid_i) begin
        r_have_prev <= 1'b1;
        r_prev_col  <= col_i;
        r_prev_row  <= row_i;
      end
    end
  end
`endif

endmodule

// File: tb/tb_window_fetcher.sv
// Directed bench for window_fetcher: interior, border-padded and offset-centre instances.
module tb_window_fetcher;

  localparam int DW = 8;
  localparam int IW = 5;
  localparam int IH = 5;
  localparam int WB = 3 * 3 * DW;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic [DW-1:0] data  = '0;
  logic [2:0]    col   = '0;
  logic [2:0]    row   = '0;
  logic          valid = 1'b0;

  logic [WB-1:0] win0, win1, win2;
  logic [2:0]    col0, col1, col2, row0, row1, row2;
  logic          v0, v1, v2;
`ifdef WINDOW_FETCHER_SEQ_CHECK_EN
  logic          se0, se1, se2;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [WB-1:0] q_win0[$], q_win1[$], q_win2[$];
  int            q_c0[$], q_r0[$], q_cy0[$], q_c1[$], q_r1[$], q_c2[$], q_r2[$];
  int            q_trig[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  window_fetcher #(.BORDER_ENABLE(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .col_i(col), .row_i(row), .valid_i(valid),
    .window_o(win0), .col_o(col0), .row_o(row0), .valid_o(v0)
`ifdef WINDOW_FETCHER_SEQ_CHECK_EN
    , .seq_err_o(se0)
`endif
  );

  window_fetcher #(.BORDER_ENABLE(1), .BORDER_EXTENSION_CONSTANT(0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .col_i(col), .row_i(row), .valid_i(valid),
    .window_o(win1), .col_o(col1), .row_o(row1), .valid_o(v1)
`ifdef WINDOW_FETCHER_SEQ_CHECK_EN
    , .seq_err_o(se1)
`endif
  );

  window_fetcher #(.BORDER_ENABLE(0), .WINDOW_WIDTH_CENTER_OFFSET(1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .col_i(col), .row_i(row), .valid_i(valid),
    .window_o(win2), .col_o(col2), .row_o(row2), .valid_o(v2)
`ifdef WINDOW_FETCHER_SEQ_CHECK_EN
    , .seq_err_o(se2)
`endif
  );

  // Capture every emitted window away from the active edge.
  always @(negedge clk) begin
    if (v0) begin
      q_win0.push_back(win0); q_c0.push_back(int'(col0)); q_r0.push_back(int'(row0));
      q_cy0.push_back(cyc);
    end
    if (v1) begin
      q_win1.push_back(win1); q_c1.push_back(int'(col1)); q_r1.push_back(int'(row1));
    end
    if (v2) begin
      q_win2.push_back(win2); q_c2.push_back(int'(col2)); q_r2.push_back(int'(row2));
    end
  end

  function automatic logic [WB-1:0] mk9(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
    int v[9];
    logic [WB-1:0] w;
    v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    w = '0;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(v[k]);
    return w;
  endfunction

  // Window for centre (c,r) of a frame whose pixel (x,y) = base + y*5 + x, zero padded.
  function automatic logic [WB-1:0] exp_win(input int c, input int r, input int cc,
                                            input int rc, input int base);
    logic [WB-1:0] w;
    int px, py;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        px = c - cc + j;
        py = r - rc + i;
        if (px >= 0 && px < IW && py >= 0 && py < IH) w[(i*3+j)*8 +: 8] = 8'(base + py*IW + px);
      end
    end
    return w;
  endfunction

  task automatic clear_queues();
    q_win0.delete(); q_c0.delete(); q_r0.delete(); q_cy0.delete();
    q_win1.delete(); q_c1.delete(); q_r1.delete();
    q_win2.delete(); q_c2.delete(); q_r2.delete();
    q_trig.delete();
  endtask

  task automatic drive_px(input int c, input int r, input int d);
    @(posedge clk); #1;
    valid = 1'b1; col = 3'(c); row = 3'(r); data = 8'(d);
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_queues();
  endtask

  // One raster frame; border_gaps adds the idle cycles virtual pixels need.
  task automatic send_frame(input int base, input int max_gap, input bit border_gaps);
    int g;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        drive_px(c, r, base + r*IW + c);
        if (c >= 2 && r >= 2) q_trig.push_back(cyc + 1);
        g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        if (border_gaps && c == IW-1 && g < 3) g = 3;
        if (r == IH-1 && c == IW-1) g = 12;
        drive_idle(g);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; col = 3'd2; row = 3'd2; data = 8'd55;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", v0); end
    n_tests++; if (win0 !== '0) begin n_fail++; $display("FAIL reset_window: got %h expected 0", win0); end
    n_tests++; if (col0 !== 3'd0 || row0 !== 3'd0) begin n_fail++; $display("FAIL reset_coord: got (%0d,%0d) expected (0,0)", col0, row0); end
    n_tests++; if (v1 !== 1'b0 || win1 !== '0) begin n_fail++; $display("FAIL reset_border_out: got v=%b w=%h expected 0", v1, win1); end
    valid = 1'b0;
    rst = 1'b0;
    drive_idle(4);
    n_tests++; if (q_win0.size() + q_win1.size() + q_win2.size() != 0) begin
      n_fail++; $display("FAIL reset_ignored_valid: got %0d windows expected 0", q_win0.size() + q_win1.size() + q_win2.size());
    end
  endtask

  task automatic test_continuous();
    apply_reset();
    send_frame(0, 0, 1'b0);
    n_tests++; if (q_win0.size() != 9) begin n_fail++; $display("FAIL cont_count: got %0d expected 9", q_win0.size()); end
    if (q_win0.size() > 0) begin
      n_tests++; if (q_win0[0] !== mk9(0,1,2,5,6,7,10,11,12)) begin n_fail++; $display("FAIL cont_first_win: got %h expected %h", q_win0[0], mk9(0,1,2,5,6,7,10,11,12)); end
      n_tests++; if (q_c0[0] != 1 || q_r0[0] != 1) begin n_fail++; $display("FAIL cont_first_centre: got (%0d,%0d) expected (1,1)", q_c0[0], q_r0[0]); end
      n_tests++; if (q_win0[q_win0.size()-1] !== mk9(12,13,14,17,18,19,22,23,24)) begin n_fail++; $display("FAIL cont_last_win: got %h expected %h", q_win0[q_win0.size()-1], mk9(12,13,14,17,18,19,22,23,24)); end
      n_tests++; if (q_c0[q_c0.size()-1] != 3 || q_r0[q_r0.size()-1] != 3) begin n_fail++; $display("FAIL cont_last_centre: got (%0d,%0d) expected (3,3)", q_c0[q_c0.size()-1], q_r0[q_r0.size()-1]); end
    end
    for (int k = 0; k < q_win0.size() && k < 9; k++) begin
      n_tests++; if (q_win0[k] !== exp_win(k%3+1, k/3+1, 1, 1, 0)) begin n_fail++; $display("FAIL cont_win[%0d]: got %h expected %h", k, q_win0[k], exp_win(k%3+1, k/3+1, 1, 1, 0)); end
      n_tests++; if (q_cy0[k] != q_trig[k]) begin n_fail++; $display("FAIL cont_latency[%0d]: got cycle %0d expected %0d", k, q_cy0[k], q_trig[k]); end
    end
  endtask

  task automatic test_idle_gaps();
    apply_reset();
    send_frame(0, 5, 1'b0);
    n_tests++; if (q_win0.size() != 9) begin n_fail++; $display("FAIL gap_count: got %0d expected 9", q_win0.size()); end
    for (int k = 0; k < q_win0.size() && k < 9; k++) begin
      n_tests++; if (q_win0[k] !== exp_win(k%3+1, k/3+1, 1, 1, 0)) begin n_fail++; $display("FAIL gap_win[%0d]: got %h expected %h", k, q_win0[k], exp_win(k%3+1, k/3+1, 1, 1, 0)); end
      n_tests++; if (q_c0[k] != k%3+1 || q_r0[k] != k/3+1) begin n_fail++; $display("FAIL gap_centre[%0d]: got (%0d,%0d) expected (%0d,%0d)", k, q_c0[k], q_r0[k], k%3+1, k/3+1); end
      n_tests++; if (q_cy0[k] != q_trig[k]) begin n_fail++; $display("FAIL gap_latency[%0d]: got cycle %0d expected %0d", k, q_cy0[k], q_trig[k]); end
    end
  endtask

  task automatic test_border();
    apply_reset();
    send_frame(0, 0, 1'b1);
    n_tests++; if (q_win1.size() != 25) begin n_fail++; $display("FAIL border_count: got %0d expected 25", q_win1.size()); end
    if (q_win1.size() == 25) begin
      n_tests++; if (q_win1[0] !== mk9(0,0,0,0,0,1,0,5,6)) begin n_fail++; $display("FAIL border_c00: got %h expected %h", q_win1[0], mk9(0,0,0,0,0,1,0,5,6)); end
      n_tests++; if (q_win1[24] !== mk9(18,19,0,23,24,0,0,0,0)) begin n_fail++; $display("FAIL border_c44: got %h expected %h", q_win1[24], mk9(18,19,0,23,24,0,0,0,0)); end
      n_tests++; if (q_c1[24] != 4 || q_r1[24] != 4) begin n_fail++; $display("FAIL border_c44_centre: got (%0d,%0d) expected (4,4)", q_c1[24], q_r1[24]); end
    end
    for (int k = 0; k < q_win1.size() && k < 25; k++) begin
      n_tests++; if (q_win1[k] !== exp_win(k%5, k/5, 1, 1, 0) || q_c1[k] != k%5 || q_r1[k] != k/5) begin
        n_fail++; $display("FAIL border_win[%0d]: got %h at (%0d,%0d) expected %h at (%0d,%0d)", k, q_win1[k], q_c1[k], q_r1[k], exp_win(k%5, k/5, 1, 1, 0), k%5, k/5);
      end
    end
  endtask

  task automatic test_center_offset();
    apply_reset();
    send_frame(0, 0, 1'b0);
    n_tests++; if (q_win2.size() != 9) begin n_fail++; $display("FAIL offset_count: got %0d expected 9", q_win2.size()); end
    if (q_win2.size() > 0) begin
      n_tests++; if (q_c2[0] != 2 || q_r2[0] != 1) begin n_fail++; $display("FAIL offset_centre: got (%0d,%0d) expected (2,1)", q_c2[0], q_r2[0]); end
      n_tests++; if (q_win2[0] !== mk9(0,1,2,5,6,7,10,11,12)) begin n_fail++; $display("FAIL offset_win: got %h expected %h", q_win2[0], mk9(0,1,2,5,6,7,10,11,12)); end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send_frame(0, 0, 1'b1);
    clear_queues();
    send_frame(100, 0, 1'b1);
    n_tests++; if (q_win0.size() != 9) begin n_fail++; $display("FAIL b2b_count: got %0d expected 9", q_win0.size()); end
    n_tests++; if (q_win1.size() != 25) begin n_fail++; $display("FAIL b2b_border_count: got %0d expected 25", q_win1.size()); end
    for (int k = 0; k < q_win0.size() && k < 9; k++) begin
      n_tests++; if (q_win0[k] !== exp_win(k%3+1, k/3+1, 1, 1, 100)) begin n_fail++; $display("FAIL b2b_win[%0d]: got %h expected %h", k, q_win0[k], exp_win(k%3+1, k/3+1, 1, 1, 100)); end
    end
    for (int k = 0; k < q_win1.size() && k < 25; k++) begin
      n_tests++; if (q_win1[k] !== exp_win(k%5, k/5, 1, 1, 100)) begin n_fail++; $display("FAIL b2b_border_win[%0d]: got %h expected %h", k, q_win1[k], exp_win(k%5, k/5, 1, 1, 100)); end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (r < 2 || c < 4) drive_px(c, r, r*IW + c);
      end
    end
    drive_px(4, 2, 14);
    n_tests++; if (v0 !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b expected 1", v0); end
    #1 rst = 1'b1;
    #1;
    n_tests++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL midrst_async_valid: got %b expected 0", v0); end
    n_tests++; if (win0 !== '0) begin n_fail++; $display("FAIL midrst_async_window: got %h expected 0", win0); end
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_queues();
    send_frame(0, 0, 1'b0);
    n_tests++; if (q_win0.size() != 9) begin n_fail++; $display("FAIL midrst_count: got %0d expected 9", q_win0.size()); end
    for (int k = 0; k < q_win0.size() && k < 9; k++) begin
      n_tests++; if (q_win0[k] !== exp_win(k%3+1, k/3+1, 1, 1, 0)) begin n_fail++; $display("FAIL midrst_win[%0d]: got %h expected %h", k, q_win0[k], exp_win(k%3+1, k/3+1, 1, 1, 0)); end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_idle_gaps();
    test_border();
    test_center_offset();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
